// File: rtl/mult_arbiter_if.sv
// Signal bundle between two requesters, the shared shift-add multiplier and mult_arbiter.
// req is held until the one-cycle gnt pulse; rsp_valid is a one-cycle pulse with no back-pressure.
interface mult_arbiter_if #(
    parameter int WIDTH = 32
);
    logic               req0;
    logic [WIDTH-1:0]   a0;
    logic [WIDTH-1:0]   b0;
    logic               req1;
    logic [WIDTH-1:0]   a1;
    logic [WIDTH-1:0]   b1;
    logic               gnt0;
    logic               gnt1;
    logic               rsp_valid0;
    logic               rsp_valid1;
    logic [2*WIDTH-1:0] result;
    logic               err;
    logic               busy;
    logic               mul_go;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [2:0]         dbg_state;

    modport slave (
        input  req0, a0, b0, req1, a1, b1, mul_done, mul_product,
        output gnt0, gnt1, rsp_valid0, rsp_valid1, result, err, busy,
               mul_go, mul_a, mul_b, dbg_state
    );

    modport master (
        output req0, a0, b0, req1, a1, b1, mul_done, mul_product,
        input  gnt0, gnt1, rsp_valid0, rsp_valid1, result, err, busy,
               mul_go, mul_a, mul_b, dbg_state
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one iterative multiplier between two requesters,
// with a watchdog that aborts a multiply that never signals done.
module mult_arbiter #(
    parameter int WIDTH      = 32,
    parameter int MAX_CYCLES = 40
) (
    input  logic          CLK,
    input  logic          reset,
    mult_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    state_e             state_q;
    logic               owner_q;
    logic               last_q;
    logic               owner_d;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   mul_a_q;
    logic [WIDTH-1:0]   mul_b_q;
    logic [2*WIDTH-1:0] result_q;
    logic               gnt0_q;
    logic               gnt1_q;
    logic               rsp0_q;
    logic               rsp1_q;
    logic               err_q;
    logic               busy_q;
    logic               go_q;

    // On a tie the requester not served last wins.
    always_comb begin
        owner_d = 1'b0;
        if (bus.req0 && bus.req1) begin
            owner_d = ~last_q;
        end else if (bus.req1) begin
            owner_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            count_q  <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            result_q <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
            err_q  <= 1'b0;
            go_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner_q <= owner_d;
                        mul_a_q <= owner_d ? bus.a1 : bus.a0;
                        mul_b_q <= owner_d ? bus.b1 : bus.b0;
                        gnt0_q  <= ~owner_d;
                        gnt1_q  <= owner_d;
                        go_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    count_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the last allowed cycle still counts as success.
                    if (bus.mul_done) begin
                        result_q <= bus.mul_product;
                        rsp0_q   <= ~owner_q;
                        rsp1_q   <= owner_q;
                        state_q  <= S_RESP;
                    end else if (count_q == CNT_MAX) begin
                        result_q <= '0;
                        rsp0_q   <= ~owner_q;
                        rsp1_q   <= owner_q;
                        err_q    <= 1'b1;
                        state_q  <= S_ERR;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                S_RESP, S_ERR: begin
                    last_q  <= owner_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.rsp_valid0 = rsp0_q;
    assign bus.rsp_valid1 = rsp1_q;
    assign bus.result     = result_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;
    assign bus.mul_go     = go_q;
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.dbg_state  = state_q;
endmodule
